// File: rtl/trace_commit_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_commit_buffer_if
//  Purpose  : Bundles the commit-side record inputs, the debug_wb_* trace
//             outputs and the status/accounting outputs of the trace commit
//             buffer into one interface.
//  Modports : slave  - the buffer itself (takes commit records, drives trace)
//             master - the environment (core commit stage + trace consumer)
//  Signals  : in_valid/in_pc/in_wb_ena/in_wb_reg/in_wb_value  commit records
//             in_stall                                        commit hold
//             out_ready + debug_wb_*                          trace handshake
//             count/overflow/drop_cnt                         status
//  Revision : 1.0 - initial release
// ============================================================================
interface trace_commit_buffer_if #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int PC_W     = 32,
    parameter int DATA_W   = 32
);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    // Commit side
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS*PC_W-1:0]   in_pc;
    logic [CHANNELS-1:0]        in_wb_ena;
    logic [CHANNELS*5-1:0]      in_wb_reg;
    logic [CHANNELS*DATA_W-1:0] in_wb_value;
    logic                       in_stall;

    // Trace side
    logic                       out_ready;
    logic                       debug_wb_have_inst;
    logic [PC_W-1:0]            debug_wb_pc;
    logic                       debug_wb_ena;
    logic [4:0]                 debug_wb_reg;
    logic [DATA_W-1:0]          debug_wb_value;

    // Status
    logic [C_CNT_W-1:0]         count;
    logic                       overflow;
    logic [15:0]                drop_cnt;

    modport slave (
        input  in_valid, in_pc, in_wb_ena, in_wb_reg, in_wb_value, out_ready,
        output in_stall, debug_wb_have_inst, debug_wb_pc, debug_wb_ena,
               debug_wb_reg, debug_wb_value, count, overflow, drop_cnt
    );

    modport master (
        output in_valid, in_pc, in_wb_ena, in_wb_reg, in_wb_value, out_ready,
        input  in_stall, debug_wb_have_inst, debug_wb_pc, debug_wb_ena,
               debug_wb_reg, debug_wb_value, count, overflow, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/trace_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_commit_buffer
//  Purpose  : Queues up to CHANNELS retired-instruction records per cycle in a
//             DEPTH-entry circular buffer and replays them one per cycle, in
//             program order, on the debug_wb_* trace interface (first-word
//             fall-through, valid/ready). Stalls the core when space for a
//             full commit group cannot be guaranteed and counts any records
//             that arrive while stalled.
//  Ports    : cpu_clk  - single rising-edge clock
//             cpu_rst  - asynchronous active-high reset
//             bus      - trace_commit_buffer_if.slave (commit inputs, trace
//                        outputs, count/overflow/drop_cnt status)
//  Revision : 1.0 - initial release
// ============================================================================
module trace_commit_buffer #(
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 8,
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int FILTER_X0 = 1
) (
    input  wire logic             cpu_clk,
    input  wire logic             cpu_rst,
    trace_commit_buffer_if.slave  bus
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    // ------------------------------------------------------------------
    // Storage (never reset: stale contents are unreachable once the
    // pointers and count are cleared)
    // ------------------------------------------------------------------
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [DEPTH-1:0]   r_mem_ena;
    logic [4:0]         r_mem_reg   [DEPTH];
    logic [DATA_W-1:0]  r_mem_value [DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [C_CNT_W-1:0] w_push_num;                // popcount(in_valid)
    logic [C_PTR_W-1:0] w_slot_ofs  [CHANNELS];    // compacted slot offset
    logic [C_PTR_W-1:0] w_slot_addr [CHANNELS];
    logic [CHANNELS-1:0] w_store_ena;
    logic [C_CNT_W-1:0] w_free;
    logic               w_stall;
    logic               w_push_en;
    logic               w_pop;
    logic               w_have;
    logic [C_CNT_W-1:0] w_pushed;
    logic [C_CNT_W-1:0] w_count_next;
    logic [16:0]        w_drop_sum;

    // Each valid channel lands at wr_ptr + (number of valid channels below
    // it), so gaps in in_valid never leave holes in the buffer. The address
    // add wraps naturally, which handles a group straddling DEPTH-1 -> 0.
    always_comb begin
        w_push_num = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_slot_ofs[i]  = w_push_num[C_PTR_W-1:0];
            w_slot_addr[i] = r_wr_ptr + w_push_num[C_PTR_W-1:0];
            w_push_num     = w_push_num + C_CNT_W'(bus.in_valid[i]);
        end
    end

    // x0 writes are architecturally invisible; optionally suppress their
    // enable so the trace consumer does not report a write to x0.
    generate
        if (FILTER_X0 != 0) begin : g_filter_x0
            always_comb begin
                w_store_ena = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    w_store_ena[i] = bus.in_wb_ena[i] &
                                     (bus.in_wb_reg[i*5 +: 5] != 5'd0);
                end
            end
        end else begin : g_no_filter
            assign w_store_ena = bus.in_wb_ena;
        end
    endgenerate

    // Stall looks only at registered occupancy: a same-cycle pop is not
    // credited, which keeps in_stall free of any path from out_ready.
    assign w_free    = C_CNT_W'(DEPTH) - r_count;
    assign w_stall   = w_free < C_CNT_W'(CHANNELS);
    assign w_push_en = ~w_stall;
    assign w_have    = (r_count != '0);
    assign w_pop     = w_have & bus.out_ready;

    assign w_pushed     = w_push_en ? w_push_num : '0;
    assign w_count_next = r_count + w_pushed - C_CNT_W'(w_pop);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + 17'(w_push_num);

    // ------------------------------------------------------------------
    // Record storage write
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (w_push_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.in_valid[i]) begin
                    r_mem_pc[w_slot_addr[i]]    <= bus.in_pc[i*PC_W +: PC_W];
                    r_mem_ena[w_slot_addr[i]]   <= w_store_ena[i];
                    r_mem_reg[w_slot_addr[i]]   <= bus.in_wb_reg[i*5 +: 5];
                    r_mem_value[w_slot_addr[i]] <= bus.in_wb_value[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and drop accounting
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_en) begin
                // push_num <= CHANNELS < DEPTH, so the truncation is exact
                r_wr_ptr <= r_wr_ptr + w_push_num[C_PTR_W-1:0];
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // A stalled cycle with no valid channel loses nothing.
            if (w_stall && (w_push_num != '0)) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through head; zeros whenever empty (including the
    // instant reset asserts, since count clears asynchronously)
    // ------------------------------------------------------------------
    always_comb begin
        bus.debug_wb_have_inst = w_have;
        bus.debug_wb_pc        = '0;
        bus.debug_wb_ena       = 1'b0;
        bus.debug_wb_reg       = '0;
        bus.debug_wb_value     = '0;
        if (w_have) begin
            bus.debug_wb_pc    = r_mem_pc[r_rd_ptr];
            bus.debug_wb_ena   = r_mem_ena[r_rd_ptr];
            bus.debug_wb_reg   = r_mem_reg[r_rd_ptr];
            bus.debug_wb_value = r_mem_value[r_rd_ptr];
        end
    end

    assign bus.in_stall = w_stall;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trace_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_commit_buffer
//  Purpose  : Self-checking bench for trace_commit_buffer (CHANNELS=2,
//             DEPTH=8). A queue-of-records model predicts the trace stream,
//             occupancy, stall and drop accounting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_commit_buffer;

    localparam int CH     = 2;
    localparam int DEPTH  = 8;
    localparam int PC_W   = 32;
    localparam int DATA_W = 32;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;

    trace_commit_buffer_if #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W),
                             .DATA_W(DATA_W)) bus ();

    trace_commit_buffer #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W),
                          .DATA_W(DATA_W), .FILTER_X0(1)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic              ena;
        logic [4:0]        rg;
        logic [DATA_W-1:0] val;
    } rec_t;

    // Reference model state
    rec_t m_q[$];
    bit   m_ovf;
    int   m_drop;

    // Per-channel stimulus fields, set by tests before drive_cycle
    logic [PC_W-1:0]   t_pc  [CH];
    logic              t_ena [CH];
    logic [4:0]        t_reg [CH];
    logic [DATA_W-1:0] t_val [CH];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [PC_W+1+5+DATA_W-1:0] model_head();
        if (m_q.size() == 0) return '0;
        return {m_q[0].pc, m_q[0].ena, m_q[0].rg, m_q[0].val};
    endfunction

    function automatic bit model_stall();
        return (DEPTH - m_q.size()) < CH;
    endfunction

    // Drives one cycle of stimulus, advances to the following negedge and
    // updates the model by the buffer's rules. No comparisons here.
    task automatic drive_cycle(input logic [CH-1:0] v, input logic rdy);
        bit stall;
        int n;
        rec_t r;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        for (int i = 0; i < CH; i++) begin
            bus.in_pc[i*PC_W +: PC_W]         = t_pc[i];
            bus.in_wb_ena[i]                  = t_ena[i];
            bus.in_wb_reg[i*5 +: 5]           = t_reg[i];
            bus.in_wb_value[i*DATA_W +: DATA_W] = t_val[i];
        end
        stall = model_stall();
        n = $countones(v);
        @(posedge cpu_clk);
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (stall) begin
            if (n > 0) m_ovf = 1'b1;
            m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (v[i]) begin
                    r.pc  = t_pc[i];
                    r.ena = t_ena[i] && (t_reg[i] != 5'd0);
                    r.rg  = t_reg[i];
                    r.val = t_val[i];
                    m_q.push_back(r);
                end
            end
        end
        @(negedge cpu_clk);
        bus.in_valid = '0;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        bus.in_pc = '0; bus.in_wb_ena = '0; bus.in_wb_reg = '0; bus.in_wb_value = '0;
        do_reset();
        n_checks++;
        if (bus.count !== 4'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_checks++;
        if (bus.debug_wb_have_inst !== 1'b0) begin n_errors++; $display("FAIL reset_have got=%b exp=0", bus.debug_wb_have_inst); end
        n_checks++;
        if (bus.debug_wb_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got=%h exp=0", bus.debug_wb_pc); end
        n_checks++;
        if (bus.in_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", bus.in_stall); end
        n_checks++;
        if ({bus.overflow, bus.drop_cnt} !== 17'h0) begin n_errors++; $display("FAIL reset_ovf_drop got=%b/%0d exp=0/0", bus.overflow, bus.drop_cnt); end
    endtask

    task automatic test_dual_push();
        t_pc[0] = 32'h1c000000; t_reg[0] = 5'd5; t_ena[0] = 1'b1; t_val[0] = 32'h12;
        t_pc[1] = 32'h1c000004; t_reg[1] = 5'd0; t_ena[1] = 1'b1; t_val[1] = 32'h34;
        drive_cycle(2'b11, 1'b1);
        n_checks++;
        if ({bus.debug_wb_have_inst, bus.debug_wb_pc, bus.debug_wb_reg, bus.debug_wb_ena, bus.debug_wb_value} !== {1'b1, 32'h1c000000, 5'd5, 1'b1, 32'h12})
        begin n_errors++; $display("FAIL dual_head0 got pc=%h reg=%0d ena=%b val=%h exp pc=1c000000 reg=5 ena=1 val=12", bus.debug_wb_pc, bus.debug_wb_reg, bus.debug_wb_ena, bus.debug_wb_value); end
        n_checks++;
        if (bus.count !== 4'd2) begin n_errors++; $display("FAIL dual_count got=%0d exp=2", bus.count); end
        drive_cycle(2'b00, 1'b1);
        n_checks++;
        if ({bus.debug_wb_have_inst, bus.debug_wb_pc, bus.debug_wb_ena} !== {1'b1, 32'h1c000004, 1'b0})
        begin n_errors++; $display("FAIL dual_head1_x0 got have=%b pc=%h ena=%b exp have=1 pc=1c000004 ena=0", bus.debug_wb_have_inst, bus.debug_wb_pc, bus.debug_wb_ena); end
        drive_cycle(2'b00, 1'b1);
        n_checks++;
        if ({bus.debug_wb_have_inst, bus.count} !== {1'b0, 4'd0}) begin n_errors++; $display("FAIL dual_drained got have=%b count=%0d exp 0/0", bus.debug_wb_have_inst, bus.count); end
    endtask

    task automatic test_compaction();
        t_pc[0] = 32'hbad0bad0; t_reg[0] = 5'd1; t_ena[0] = 1'b1; t_val[0] = 32'h0;
        t_pc[1] = 32'h1c000010; t_reg[1] = 5'd7; t_ena[1] = 1'b1; t_val[1] = 32'h77;
        drive_cycle(2'b10, 1'b0);
        n_checks++;
        if (bus.count !== 4'd1) begin n_errors++; $display("FAIL compact_count got=%0d exp=1", bus.count); end
        n_checks++;
        if (bus.debug_wb_pc !== 32'h1c000010) begin n_errors++; $display("FAIL compact_pc got=%h exp=1c000010", bus.debug_wb_pc); end
        drive_cycle(2'b00, 1'b1);
        n_checks++;
        if (bus.count !== 4'd0) begin n_errors++; $display("FAIL compact_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            t_pc[0] = 32'h30000000 + 32'(8*k); t_reg[0] = 5'(k+1); t_ena[0] = 1'b1; t_val[0] = 32'(k);
            t_pc[1] = 32'h30000004 + 32'(8*k); t_reg[1] = 5'(k+9); t_ena[1] = 1'b0; t_val[1] = 32'(k+100);
            drive_cycle(2'b11, 1'b0);
        end
        n_checks++;
        if ({bus.count, bus.in_stall} !== {4'd6, 1'b0}) begin n_errors++; $display("FAIL bp_count6 got count=%0d stall=%b exp 6/0", bus.count, bus.in_stall); end
        n_checks++;
        if (bus.debug_wb_pc !== 32'h30000000) begin n_errors++; $display("FAIL bp_head_stable got=%h exp=30000000", bus.debug_wb_pc); end
        t_pc[0] = 32'h30000018; t_pc[1] = 32'h3000001c;
        drive_cycle(2'b11, 1'b0);
        n_checks++;
        if ({bus.count, bus.in_stall} !== {4'd8, 1'b1}) begin n_errors++; $display("FAIL bp_full got count=%0d stall=%b exp 8/1", bus.count, bus.in_stall); end
        t_pc[0] = 32'h3000ffff; t_pc[1] = 32'h3000fffe;
        drive_cycle(2'b11, 1'b0);
        n_checks++;
        if ({bus.overflow, bus.drop_cnt, bus.count} !== {1'b1, 16'd2, 4'd8})
        begin n_errors++; $display("FAIL bp_drop got ovf=%b drop=%0d count=%0d exp 1/2/8", bus.overflow, bus.drop_cnt, bus.count); end
        drive_cycle(2'b00, 1'b0);
        n_checks++;
        if ({bus.overflow, bus.drop_cnt} !== {1'b1, 16'd2}) begin n_errors++; $display("FAIL bp_idle_stalled got ovf=%b drop=%0d exp 1/2", bus.overflow, bus.drop_cnt); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({bus.debug_wb_pc, bus.debug_wb_ena, bus.debug_wb_reg, bus.debug_wb_value} !== model_head())
            begin n_errors++; $display("FAIL bp_drain%0d got pc=%h exp pc=%h", k, bus.debug_wb_pc, m_q.size() ? m_q[0].pc : 32'h0); end
            drive_cycle(2'b00, 1'b1);
        end
        n_checks++;
        if ({bus.debug_wb_have_inst, bus.overflow} !== {1'b0, 1'b1}) begin n_errors++; $display("FAIL bp_sticky got have=%b ovf=%b exp 0/1", bus.debug_wb_have_inst, bus.overflow); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            t_pc[0] = 32'h20000000 + 32'(4*k); t_reg[0] = 5'd3; t_ena[0] = 1'b1; t_val[0] = 32'(k);
            drive_cycle(2'b01, 1'b1);
            n_checks++;
            if ({bus.count, bus.debug_wb_pc} !== {4'd1, 32'h20000000 + 32'(4*k)})
            begin n_errors++; $display("FAIL wrap%0d got count=%0d pc=%h exp 1/%h", k, bus.count, bus.debug_wb_pc, 32'h20000000 + 32'(4*k)); end
        end
        drive_cycle(2'b00, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            t_pc[0] = 32'h40000000 + 32'(8*k); t_reg[0] = 5'd2; t_ena[0] = 1'b1; t_val[0] = 32'h5;
            t_pc[1] = 32'h40000004 + 32'(8*k); t_reg[1] = 5'd4; t_ena[1] = 1'b1; t_val[1] = 32'h6;
            drive_cycle(k == 2 ? 2'b01 : 2'b11, 1'b0);
        end
        n_checks++;
        if (bus.count !== 4'd5) begin n_errors++; $display("FAIL midrst_pre got=%0d exp=5", bus.count); end
        #2 cpu_rst = 1'b1;
        m_q.delete(); m_ovf = 1'b0; m_drop = 0;
        #1;
        n_checks++;
        if ({bus.debug_wb_have_inst, bus.count, bus.debug_wb_pc} !== {1'b0, 4'd0, 32'h0})
        begin n_errors++; $display("FAIL midrst_async got have=%b count=%0d pc=%h exp 0/0/0", bus.debug_wb_have_inst, bus.count, bus.debug_wb_pc); end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        t_pc[0] = 32'hdead0000; t_reg[0] = 5'd9; t_ena[0] = 1'b1; t_val[0] = 32'h99;
        drive_cycle(2'b01, 1'b0);
        n_checks++;
        if ({bus.count, bus.debug_wb_pc, bus.debug_wb_reg} !== {4'd1, 32'hdead0000, 5'd9})
        begin n_errors++; $display("FAIL midrst_post got count=%0d pc=%h reg=%0d exp 1/dead0000/9", bus.count, bus.debug_wb_pc, bus.debug_wb_reg); end
    endtask

    task automatic test_random();
        logic [CH-1:0] v;
        logic rdy;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < CH; i++) begin
                t_pc[i]  = $urandom;
                t_ena[i] = 1'($urandom_range(0, 1));
                t_reg[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                t_val[i] = $urandom;
            end
            v   = CH'($urandom_range(0, 3));
            rdy = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive_cycle(v, rdy);
            n_checks++;
            if (bus.count !== 4'(m_q.size())) begin n_errors++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", k, bus.count, m_q.size()); end
            n_checks++;
            if ({bus.debug_wb_have_inst, bus.in_stall} !== {m_q.size() != 0, model_stall()})
            begin n_errors++; $display("FAIL rnd_have_stall@%0d got=%b/%b exp=%b/%b", k, bus.debug_wb_have_inst, bus.in_stall, m_q.size() != 0, model_stall()); end
            n_checks++;
            if ({bus.debug_wb_pc, bus.debug_wb_ena, bus.debug_wb_reg, bus.debug_wb_value} !== model_head())
            begin n_errors++; $display("FAIL rnd_head@%0d got=%h exp=%h", k, {bus.debug_wb_pc, bus.debug_wb_ena, bus.debug_wb_reg, bus.debug_wb_value}, model_head()); end
            n_checks++;
            if ({bus.overflow, bus.drop_cnt} !== {m_ovf, 16'(m_drop)})
            begin n_errors++; $display("FAIL rnd_drop@%0d got=%b/%0d exp=%b/%0d", k, bus.overflow, bus.drop_cnt, m_ovf, m_drop); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            t_pc[i] = '0; t_ena[i] = 1'b0; t_reg[i] = '0; t_val[i] = '0;
        end
        m_ovf = 1'b0;
        m_drop = 0;
        @(negedge cpu_clk);
        test_reset();
        test_dual_push();
        test_compaction();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
